// File: rtl/mult_seq_radix.sv
// Sequential shift-add multiplier retiring K multiplier bits per cycle, with
// per-transaction signed/unsigned mode and valid/ready handshakes on both sides.
module mult_seq_radix #(
  parameter int W1 = 8,
  parameter int W2 = 8,
  parameter int K  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [W1-1:0]    IN1,
  input  logic [W2-1:0]    IN2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W1+W2-1:0] Out,
  output logic             busy
);

  localparam int P  = W1 + W2;
  localparam int N  = W1 / K;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  generate
    if (W1 < 2 || W2 < 2 || K < 1 || (W1 % K) != 0) begin : g_bad_param
      $error("mult_seq_radix: need W1>=2, W2>=2 and K dividing W1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W1-1:0]   a_reg;
  logic [P-1:0]    mcand_reg;
  logic            sgn_reg;
  logic [P-1:0]    acc_reg;
  logic [P-1:0]    out_reg;
  logic [CW-1:0]   cnt_reg;
  logic            accept;
  logic            last;
  logic [P-1:0]    step;
  logic [P-1:0]    acc_next;
  logic [P-1:0]    pp [K];

  assign accept   = in_valid && in_ready;
  assign last     = (cnt_reg == LAST);
  assign acc_next = acc_reg + step;
  assign Out      = out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // a_reg shifts right and mcand_reg left each iteration, so slice bit gi
  // always weighs mcand_reg << gi at its absolute position.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_pp
      assign pp[gi] = a_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // The top bit of the last slice is IN1's sign bit: negative weight when signed.
  always_comb begin
    step = '0;
    for (int j = 0; j < K; j++) begin
      if (sgn_reg && last && (j == K - 1)) step = step - pp[j];
      else                                 step = step + pp[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      mcand_reg <= '0;
      sgn_reg   <= 1'b0;
      acc_reg   <= '0;
      out_reg   <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= IN1;
      mcand_reg <= {{W1{in_signed & IN2[W2-1]}}, IN2};
      sgn_reg   <= in_signed;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == CALC) begin
      a_reg     <= a_reg >> K;
      mcand_reg <= mcand_reg << K;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_reg + ONE;
      if (last) out_reg <= acc_next;
    end
  end

endmodule
